// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer.
//   MODE_*  : playback mode encodings as seen on the mode input
//   state_t : sequencer state (idle / playing)
//   dir_t   : playback direction used by bounce mode
package led_seq_pkg;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_LOOP    = 2'd1;
  localparam logic [1:0] MODE_BOUNCE  = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/led_tick_gen.sv
// Frame-rate prescaler for the LED pattern sequencer.
// Counts 0..DIV-1 while enabled and emits a one-cycle tick in the cycle the
// count sits at DIV-1; the count then wraps to 0.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   en    : count enable (low holds the count)
//   clr   : synchronous clear, wins over en
//   tick  : high for the cycle in which count == DIV-1 and en is high
module led_tick_gen #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Gated by en so a paused sequencer never sees a step.
  assign tick = en && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: plays CHANNELS-bit frames from a writable DEPTH-entry
// frame memory, one frame step every DIV clocks, in one-shot, loop or bounce
// mode.
//   CLK100MHZ : system clock
//   RST_N     : asynchronous active-low reset
//   wr_en     : frame memory write strobe (any state)
//   wr_addr   : frame write address
//   wr_data   : frame write data
//   len       : frames to play, clamped to 1..DEPTH, sampled on start
//   mode      : 0 one-shot, 1 loop, 2 bounce, 3 behaves as loop; sampled on start
//   start     : restart pulse (beats stop)
//   stop      : stop pulse, blanks the LEDs
//   pause     : level, freezes playback
//   LED       : current frame
//   busy      : high while playing
//   done      : one-cycle pulse when a one-shot run finishes
//   wrap      : one-cycle pulse on loop wrap or bounce turn-around
//   idx       : index of the frame currently shown
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16,
  parameter int DIV      = 25_000_000
) (
  input  logic                       CLK100MHZ,
  input  logic                       RST_N,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [CHANNELS-1:0]        wr_data,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic [1:0]                 mode,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       pause,
  output logic [CHANNELS-1:0]        LED,
  output logic                       busy,
  output logic                       done,
  output logic                       wrap,
  output logic [$clog2(DEPTH)-1:0]   idx
);

  localparam int            IW      = $clog2(DEPTH);
  localparam logic [IW:0]   LEN_MAX = (IW+1)'(DEPTH);

  logic [CHANNELS-1:0] mem [DEPTH];

  state_t        state;
  dir_t          dir;
  logic [IW:0]   len_r;
  logic [1:0]    mode_r;
  logic          run_en;
  logic          tick;

  logic [IW-1:0] last;
  logic [IW-1:0] idx_nxt;
  dir_t          dir_nxt;
  logic          wrap_nxt;
  logic          fin_nxt;

  function automatic logic [IW:0] clamp_len(input logic [IW:0] l);
    if (l == '0) begin
      return (IW+1)'(1);
    end
    if (l > LEN_MAX) begin
      return LEN_MAX;
    end
    return l;
  endfunction

  // Frame memory has no reset; the read in the FSM sees the pre-write value
  // when the same address is written on the same edge.
  always_ff @(posedge CLK100MHZ) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign run_en = (state == ST_RUN) && !pause;
  assign busy   = (state == ST_RUN);

  led_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (CLK100MHZ),
    .rst_n (RST_N),
    .en    (run_en),
    .clr   (start),
    .tick  (tick)
  );

  // len_r is always 1..DEPTH, so last always fits in an index.
  assign last = IW'(len_r - (IW+1)'(1));

  // Next frame index for the current mode, applied only on a tick.
  always_comb begin
    idx_nxt  = idx;
    dir_nxt  = dir;
    wrap_nxt = 1'b0;
    fin_nxt  = 1'b0;
    case (mode_r)
      MODE_ONESHOT: begin
        if (idx < last) begin
          idx_nxt = idx + 1'b1;
        end else begin
          fin_nxt = 1'b1;
        end
      end
      MODE_BOUNCE: begin
        if (dir == DIR_UP) begin
          if (idx == last) begin
            // A single-frame pattern turns around in place.
            dir_nxt  = DIR_DOWN;
            wrap_nxt = 1'b1;
            idx_nxt  = (idx == '0) ? idx : idx - 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          if (idx == '0) begin
            dir_nxt  = DIR_UP;
            wrap_nxt = 1'b1;
            idx_nxt  = (last == '0) ? idx : idx + 1'b1;
          end else begin
            idx_nxt = idx - 1'b1;
          end
        end
      end
      default: begin
        // Loop, and the reserved encoding.
        if (idx == last) begin
          idx_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      dir    <= DIR_UP;
      idx    <= '0;
      LED    <= '0;
      done   <= 1'b0;
      wrap   <= 1'b0;
      len_r  <= (IW+1)'(1);
      mode_r <= MODE_ONESHOT;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      if (start) begin
        state  <= ST_RUN;
        dir    <= DIR_UP;
        idx    <= '0;
        LED    <= mem[0];
        len_r  <= clamp_len(len);
        mode_r <= mode;
      end else if (stop && (state == ST_RUN)) begin
        state <= ST_IDLE;
        idx   <= '0;
        LED   <= '0;
      end else if (tick) begin
        // tick only fires in RUN with pause low.
        wrap <= wrap_nxt;
        if (fin_nxt) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end else begin
          idx <= idx_nxt;
          dir <= dir_nxt;
          LED <= mem[idx_nxt];
        end
      end
    end
  end

endmodule
